store_write_buffer: RTL and testbench

- Posted-store FIFO that sits directly downstream of the MIPS core's data-memory write port (memwrite / dataadr / writedata).
- Accepts stores in one cycle and drains them to data memory over a valid/ready handshake.
- Stalls the core only when the buffer is full.
- Forwards buffered data to loads that hit a pending store.

---
 rtl/swb_pkg.sv | 13 +
 rtl/swb_fwd_match.sv | 29 ++
 rtl/store_write_buffer.sv | 66 ++++++
 tb/tb_store_write_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/swb_pkg.sv
// swb_pkg: shared defaults, entry type and pointer-width helper for the store write buffer
package swb_pkg;
    localparam int SWB_DEPTH = 4;
    localparam int SWB_AW = 32;
    localparam int SWB_DW = 32;
    typedef struct packed {
        logic [SWB_AW-1:0] addr;
        logic [SWB_DW-1:0] data;
    } swb_entry_t;
    function automatic int swb_ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/swb_fwd_match.sv
// swb_fwd_match: word-address search over occupied entries, youngest match wins
module swb_fwd_match
    import swb_pkg::*;
#(
    parameter int DEPTH = SWB_DEPTH
) (
    input  swb_entry_t                      entries [DEPTH],
    input  logic [DEPTH-1:0]                valid,
    input  logic [swb_ptr_w(DEPTH)-1:0]     wr_ptr,
    input  logic [SWB_AW-1:0]               rd_addr,
    output logic                            rd_hit,
    output logic [SWB_DW-1:0]               rd_data
);
    localparam int PW = swb_ptr_w(DEPTH);
    logic [PW-1:0] idx;
    // walk oldest to youngest so the youngest match overwrites earlier ones
    always_comb begin
        rd_hit = 1'b0;
        rd_data = '0;
        idx = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wr_ptr - PW'(i);
            if (valid[idx] && ((entries[idx].addr ^ rd_addr) & ~SWB_AW'(3)) == '0) begin
                rd_hit = 1'b1;
                rd_data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between core write port and data memory, with load forwarding
module store_write_buffer
    import swb_pkg::*;
#(
    parameter int DEPTH = SWB_DEPTH,
    parameter int AW = SWB_AW,
    parameter int DW = SWB_DW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memwrite,
    input  logic [AW-1:0]               dataadr,
    input  logic [DW-1:0]               writedata,
    output logic                        stall,
    output logic                        mem_valid,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic                        mem_ready,
    input  logic [AW-1:0]               rd_addr,
    output logic                        rd_hit,
    output logic [DW-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);
    localparam int PW = swb_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    swb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DEPTH-1:0] valid;
    logic push, pop;
    assign empty = count == '0;
    assign stall = memwrite && count == CW'(DEPTH);
    assign push = memwrite && !stall;
    assign pop = mem_valid && mem_ready;
    assign mem_valid = !empty;
    assign mem_addr = mem_valid ? mem[rd_ptr].addr : '0;
    assign mem_wdata = mem_valid ? mem[rd_ptr].data : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: dataadr, data: writedata};
    end
    // an entry is occupied when its distance from the head is below count
    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++)
            valid[j] = {1'b0, PW'(j) - rd_ptr} < count;
    end
    swb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries(mem),
        .valid(valid),
        .wr_ptr(wr_ptr),
        .rd_addr(rd_addr),
        .rd_hit(rd_hit),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: queue-model scoreboard plus directed scenarios for store_write_buffer
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic reset = 1;
    logic memwrite = 0;
    logic [31:0] dataadr = 0, writedata = 0, rd_addr = 0;
    logic mem_ready = 0;
    logic stall, mem_valid, rd_hit, empty;
    logic [31:0] mem_addr, mem_wdata, rd_data;
    logic [2:0] count;
    int checks = 0, failures = 0;
    logic [63:0] q[$];
    logic [31:0] drained[$];
    bit mpush;

    store_write_buffer dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: plain queue of {addr,data}; pop decided from pre-edge occupancy
    always @(posedge clk or posedge reset) begin
        if (reset) q.delete();
        else begin
            mpush = memwrite && q.size() < DEPTH;
            if (q.size() > 0 && mem_ready) void'(q.pop_front());
            if (mpush) q.push_back({dataadr, writedata});
        end
    end

    always @(negedge clk) begin
        logic eh;
        logic [31:0] ed;
        eh = 0;
        ed = 0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!eh && q[i][63:34] == rd_addr[31:2]) begin
                eh = 1;
                ed = q[i][31:0];
            end
        chk("m_count", count, q.size());
        chk("m_empty", empty, q.size() == 0);
        chk("m_valid", mem_valid, q.size() != 0);
        chk("m_addr", mem_addr, q.size() ? q[0][63:32] : 0);
        chk("m_wdata", mem_wdata, q.size() ? q[0][31:0] : 0);
        chk("m_stall", stall, memwrite && q.size() == DEPTH);
        chk("m_rd_hit", rd_hit, eh);
        chk("m_rd_data", rd_data, ed);
        if (mem_valid && mem_ready && !reset) drained.push_back(mem_addr);
    end

    initial begin
        int maxc;
        bit sawstall;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_valid", mem_valid, 0);
        chk("rst_stall", stall, 0);
        tick();
        tick();
        reset = 0;
        // reset mid-drain
        for (int k = 0; k < 3; k++) begin
            memwrite = 1; dataadr = 32'h200 + 4 * k; writedata = k;
            tick();
        end
        memwrite = 0;
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        #2 reset = 1;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_valid", mem_valid, 0);
        chk("rst_mid_addr", mem_addr, 0);
        tick();
        reset = 0;
        tick();
        @(negedge clk);
        chk("post_rst_valid", mem_valid, 0);
        chk("post_rst_count", count, 0);
        // single store latency
        tick();
        mem_ready = 1; memwrite = 1; dataadr = 32'h54; writedata = 7;
        tick();
        memwrite = 0;
        @(negedge clk);
        chk("lat_valid", mem_valid, 1);
        chk("lat_addr", mem_addr, 32'h54);
        chk("lat_wdata", mem_wdata, 7);
        tick();
        @(negedge clk);
        chk("lat_empty", empty, 1);
        // fill and stall
        tick();
        mem_ready = 0;
        drained.delete();
        for (int k = 0; k < 4; k++) begin
            memwrite = 1; dataadr = 4 * k; writedata = 100 + k;
            tick();
        end
        dataadr = 32'h10; writedata = 104;
        @(negedge clk);
        chk("fill_count", count, 4);
        chk("fill_stall", stall, 1);
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("fill_stall_pop", stall, 1);
        chk("fill_head", mem_addr, 0);
        tick();
        mem_ready = 0;
        @(negedge clk);
        chk("fill_count3", count, 3);
        chk("fill_unstall", stall, 0);
        tick();
        memwrite = 0;
        @(negedge clk);
        chk("fill_count4", count, 4);
        mem_ready = 1;
        #1;
        repeat (4) tick();
        @(negedge clk);
        chk("fill_drained_n", drained.size(), 5);
        for (int k = 0; k < 5; k++) chk("fill_order", k < drained.size() ? drained[k] : 32'hx, 4 * k);
        // backpressure hold
        tick();
        mem_ready = 0; memwrite = 1; dataadr = 32'h20; writedata = 32'hDEAD;
        tick();
        memwrite = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_addr", mem_addr, 32'h20);
            chk("bp_wdata", mem_wdata, 32'hDEAD);
            tick();
        end
        mem_ready = 1;
        tick();
        @(negedge clk);
        chk("bp_popped", empty, 1);
        // forwarding youngest
        tick();
        mem_ready = 0;
        memwrite = 1; dataadr = 32'h40; writedata = 1; tick();
        dataadr = 32'h44; writedata = 2; tick();
        dataadr = 32'h40; writedata = 3; tick();
        memwrite = 0; rd_addr = 32'h42;
        @(negedge clk);
        chk("fwd_hit", rd_hit, 1);
        chk("fwd_data", rd_data, 3);
        tick();
        rd_addr = 32'h48;
        @(negedge clk);
        chk("fwd_miss_hit", rd_hit, 0);
        chk("fwd_miss_data", rd_data, 0);
        tick();
        rd_addr = 32'h47;
        @(negedge clk);
        chk("fwd_44_data", rd_data, 2);
        tick();
        mem_ready = 1;
        rd_addr = 32'h40;
        repeat (3) tick();
        @(negedge clk);
        chk("fwd_gone", rd_hit, 0);
        // wrap-around throughput
        tick();
        drained.delete();
        maxc = 0;
        sawstall = 0;
        for (int k = 0; k < 20; k++) begin
            memwrite = 1; dataadr = 32'h100 + 4 * k; writedata = k;
            @(negedge clk);
            if (count > maxc) maxc = count;
            if (stall) sawstall = 1;
            tick();
        end
        memwrite = 0;
        tick();
        tick();
        chk("wrap_maxcnt", maxc, 1);
        chk("wrap_stall", sawstall, 0);
        chk("wrap_n", drained.size(), 20);
        for (int k = 0; k < 20; k++) chk("wrap_order", k < drained.size() ? drained[k] : 32'hx, 32'h100 + 4 * k);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
